// File: rtl/hex_scan_ctrl.sv
// ----------------------------------------------------------------------------
// hex_scan_ctrl: 4-digit multiplexed 7-segment driver, frame-synchronous commit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hex_scan_ctrl #(
  parameter int DIV          = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       hold,
  output logic [7:0] data_old,
  output logic [7:0] data_new,
  output logic [3:0] digit_sel,
  output logic [6:0] seg,
  output logic       frame_done
);

  localparam int MAXN = (DIV > BLANK_CYCLES) ? DIV : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXN + 1);

  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  function automatic logic [6:0] hex_dec(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] pick_nibble(input logic [1:0] k,
                                             input logic [7:0] nw,
                                             input logic [7:0] od);
    logic [3:0] n;
    case (k)
      2'd0:    n = nw[3:0];
      2'd1:    n = nw[7:4];
      2'd2:    n = od[3:0];
      default: n = od[7:4];
    endcase
    return n;
  endfunction

  state_t        state_q, state_d;
  logic [1:0]    digit_q, digit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    old_q, old_d;
  logic [7:0]    new_q, new_d;
  logic [7:0]    pend_q, pend_d;
  logic          pend_valid_q, pend_valid_d;

  logic          in_ready_q, in_ready_d;
  logic [3:0]    digit_sel_q, digit_sel_d;
  logic [6:0]    seg_q, seg_d;
  logic          frame_done_q, frame_done_d;

  logic          boundary;

  always_comb begin
    state_d      = state_q;
    digit_d      = digit_q;
    cnt_d        = cnt_q;
    old_d        = old_q;
    new_d        = new_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;

    boundary = (state_q == ST_SHOW) && (digit_q == 2'd3) && (cnt_q == DIV_LAST);

    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (cnt_q == DIV_LAST) begin
          // Without blanking the next digit follows its predecessor directly.
          state_d = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
          digit_d = digit_q + 2'd1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase

    // Commit and accept are exclusive: accept needs an empty pending slot.
    if (boundary && pend_valid_q && !hold) begin
      old_d        = new_q;
      new_d        = pend_q;
      pend_valid_d = 1'b0;
    end
    if (in_valid && !pend_valid_q) begin
      pend_d       = in_data;
      pend_valid_d = 1'b1;
    end

    // Outputs are registered from next-state so they track the state registers exactly.
    in_ready_d   = !pend_valid_d;
    digit_sel_d  = (state_d == ST_SHOW) ? (4'b0001 << digit_d) : 4'b0000;
    seg_d        = (state_d == ST_SHOW) ? hex_dec(pick_nibble(digit_d, new_d, old_d)) : 7'h00;
    frame_done_d = (state_d == ST_SHOW) && (digit_d == 2'd3) && (cnt_d == DIV_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BLANK;
      digit_q      <= 2'd0;
      cnt_q        <= '0;
      old_q        <= 8'h00;
      new_q        <= 8'h00;
      pend_q       <= 8'h00;
      pend_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      digit_sel_q  <= 4'b0000;
      seg_q        <= 7'h00;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      digit_q      <= digit_d;
      cnt_q        <= cnt_d;
      old_q        <= old_d;
      new_q        <= new_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      in_ready_q   <= in_ready_d;
      digit_sel_q  <= digit_sel_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign data_old   = old_q;
  assign data_new   = new_q;
  assign digit_sel  = digit_sel_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire
